// File: rtl/xorshift_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : xorshift_pkg
// Brief  : Shared state encoding and default constants for the xorshift stream.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package xorshift_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int          c_def_sh_a     = 13;
  localparam int          c_def_sh_b     = 17;
  localparam int          c_def_sh_c     = 5;
  localparam logic [31:0] c_def_zero_sub = 32'h2545F491;

endpackage
`default_nettype wire

// File: rtl/xorshift_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : xorshift_step
// Brief  : One combinational xorshift step, all terms truncated to WIDTH.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module xorshift_step #(
  parameter int WIDTH = 32,
  parameter int SH_A  = 13,
  parameter int SH_B  = 17,
  parameter int SH_C  = 5
) (
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_y
);

  logic [WIDTH-1:0] w_t1;
  logic [WIDTH-1:0] w_t2;

  assign w_t1 = i_x ^ (i_x << SH_A);
  assign w_t2 = w_t1 ^ (w_t1 >> SH_B);
  assign o_y  = w_t2 ^ (w_t2 << SH_C);

endmodule
`default_nettype wire

// File: rtl/xorshift_stream_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : xorshift_stream_gen
// Brief  : Seed + burst-length request in, valid/ready stream of xorshift words out.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module xorshift_stream_gen
  import xorshift_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter int          SH_A     = c_def_sh_a,
  parameter int          SH_B     = c_def_sh_b,
  parameter int          SH_C     = c_def_sh_c,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] ZERO_SUB = c_def_zero_sub
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [CNT_W-1:0] len_in,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rand_num,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] c_zero_sub = WIDTH'(ZERO_SUB);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_rand;
  logic             r_valid;
  logic             r_done;

  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_seed_step;
  logic [WIDTH-1:0] w_fb_step;
  logic             w_accept;
  logic             w_xfer;

  // An all-zero seed would lock xorshift at zero forever, so substitute it.
  assign w_seed   = (seed_in == '0) ? c_zero_sub : seed_in;
  // Gating with rst_n keeps in_ready low while the block is held in reset.
  assign in_ready = rst_n && (r_state == IDLE) && !abort;
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_valid && out_ready;

  xorshift_step #(.WIDTH(WIDTH), .SH_A(SH_A), .SH_B(SH_B), .SH_C(SH_C)) u_step_seed (
    .i_x (w_seed),
    .o_y (w_seed_step)
  );

  xorshift_step #(.WIDTH(WIDTH), .SH_A(SH_A), .SH_B(SH_B), .SH_C(SH_C)) u_step_fb (
    .i_x (r_rand),
    .o_y (w_fb_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_rand      <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (len_in != '0) begin
              r_state     <= RUN;
              r_rand      <= w_seed_step;
              r_valid     <= 1'b1;
              r_remaining <= len_in;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort takes priority: a word taken this cycle still counts, but no done.
          if (abort) begin
            r_state     <= IDLE;
            r_rand      <= '0;
            r_valid     <= 1'b0;
            r_remaining <= '0;
          end else if (w_xfer) begin
            if (r_remaining == c_one) begin
              r_state     <= IDLE;
              r_rand      <= '0;
              r_valid     <= 1'b0;
              r_remaining <= '0;
              r_done      <= 1'b1;
            end else begin
              r_rand      <= w_fb_step;
              r_remaining <= r_remaining - c_one;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign rand_num  = r_rand;
  assign done      = r_done;
  assign busy      = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_xorshift_stream_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_xorshift_stream_gen
// Brief  : Directed scoreboard bench for xorshift_stream_gen (32-bit defaults).
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_xorshift_stream_gen;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] seed_in;
  logic [15:0] len_in;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rand_num;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;
  int n_valid  = 0;

  logic [31:0] exp_q[$];

  xorshift_stream_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .seed_in   (seed_in),
    .len_in    (len_in),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rand_num  (rand_num),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ {x[18:0], 13'b0};
    t = t ^ {17'b0, t[31:17]};
    t = t ^ {t[26:0], 5'b0};
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Mid-cycle sample point: scoreboard pop on transfer plus pulse bookkeeping.
  task automatic neg();
    logic [31:0] e;
    @(negedge clk);
    if (out_valid) n_valid++;
    if (done) n_done++;
    chk("done_with_valid", {31'b0, done & out_valid}, 32'h0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", rand_num, 32'hxxxxxxxx);
      end else begin
        e = exp_q.pop_front();
        chk("stream_word", rand_num, e);
      end
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic [31:0] seed, input int len);
    logic [31:0] x;
    x = (seed == 32'h0) ? 32'h2545F491 : seed;
    for (int i = 0; i < len; i++) begin
      x = model_step(x);
      exp_q.push_back(x);
    end
  endtask

  task automatic drain(input string tag);
    logic acc;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || in_valid); i++) begin
      neg();
      acc = in_valid && in_ready;
      pos();
      if (acc) in_valid = 1'b0;
    end
    chk(tag, exp_q.size(), 32'h0);
  endtask

  task automatic request(input logic [31:0] seed, input logic [15:0] len);
    seed_in  = seed;
    len_in   = len;
    in_valid = 1'b1;
    neg();
    pos();
    in_valid = 1'b0;
  endtask

  task automatic burst_seed1(input string tag);
    int d0;
    d0 = n_done;
    exp_q.push_back(32'h00042021);
    exp_q.push_back(32'h04080601);
    exp_q.push_back(32'h9DCCA8C5);
    request(32'h1, 16'd3);
    drain({tag, "_drain"});
    neg();
    chk({tag, "_done"}, {31'b0, done}, 32'h1);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'h1);
    chk({tag, "_valid_low"}, {31'b0, out_valid}, 32'h0);
    chk({tag, "_done_count"}, n_done - d0, 32'h1);
    pos();
  endtask

  initial begin
    int d0;
    int v0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    seed_in   = '0;
    len_in    = '0;
    abort     = 1'b0;
    out_ready = 1'b1;

    neg();
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_rand", rand_num, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    pos();
    rst_n = 1'b1;
    neg();
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
    pos();

    // 1) basic burst, seed=1
    burst_seed1("t1");

    // 2) backpressure holds the first word
    out_ready = 1'b0;
    exp_q.push_back(32'h00042021);
    exp_q.push_back(32'h04080601);
    exp_q.push_back(32'h9DCCA8C5);
    request(32'h1, 16'd3);
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("t2_hold_word", rand_num, 32'h00042021);
      chk("t2_hold_valid", {31'b0, out_valid}, 32'h1);
      chk("t2_busy", {31'b0, busy}, 32'h1);
      pos();
    end
    out_ready = 1'b1;
    drain("t2_drain");
    neg();
    chk("t2_done", {31'b0, done}, 32'h1);
    pos();

    // 3) zero seed substitution, then zero-length request
    push_burst(32'h0, 1);
    request(32'h0, 16'd1);
    neg();
    chk("t3_nonzero", {31'b0, rand_num == 32'h0}, 32'h0);
    pos();
    drain("t3_drain");
    neg();
    pos();
    d0 = n_done;
    v0 = n_valid;
    request(32'h1234, 16'd0);
    neg();
    chk("t3_len0_done", {31'b0, done}, 32'h1);
    chk("t3_len0_busy", {31'b0, busy}, 32'h0);
    pos();
    neg();
    chk("t3_len0_pulse", {31'b0, done}, 32'h0);
    chk("t3_len0_no_valid", n_valid - v0, 32'h0);
    chk("t3_len0_done_count", n_done - d0, 32'h1);
    pos();

    // 4) abort after second transfer of a 10-word burst
    d0 = n_done;
    push_burst(32'hDEADBEEF, 2);
    request(32'hDEADBEEF, 16'd10);
    neg(); pos();
    neg(); pos();
    out_ready = 1'b0;
    abort     = 1'b1;
    neg();
    chk("t4_busy_before", {31'b0, busy}, 32'h1);
    pos();
    abort     = 1'b0;
    out_ready = 1'b1;
    neg();
    chk("t4_valid", {31'b0, out_valid}, 32'h0);
    chk("t4_rand", rand_num, 32'h0);
    chk("t4_busy", {31'b0, busy}, 32'h0);
    chk("t4_in_ready", {31'b0, in_ready}, 32'h1);
    chk("t4_queue", exp_q.size(), 32'h0);
    pos();
    neg();
    chk("t4_no_done", n_done - d0, 32'h0);
    pos();

    // abort in IDLE blocks a simultaneous request
    seed_in  = 32'h5;
    len_in   = 16'd2;
    in_valid = 1'b1;
    abort    = 1'b1;
    neg();
    chk("idle_abort_in_ready", {31'b0, in_ready}, 32'h0);
    pos();
    in_valid = 1'b0;
    abort    = 1'b0;
    neg();
    chk("idle_abort_valid", {31'b0, out_valid}, 32'h0);
    chk("idle_abort_busy", {31'b0, busy}, 32'h0);
    pos();

    // 5) request held through RUN is taken only after in_ready returns
    d0 = n_done;
    push_burst(32'hCAFEF00D, 3);
    push_burst(32'h12345678, 2);
    request(32'hCAFEF00D, 16'd3);
    seed_in  = 32'h12345678;
    len_in   = 16'd2;
    in_valid = 1'b1;
    neg();
    chk("t5_in_ready_run", {31'b0, in_ready}, 32'h0);
    pos();
    drain("t5_drain");
    neg();
    chk("t5_done_count", n_done - d0, 32'h2);
    pos();

    // 6) reset mid-burst, then seed=1 repeats the first sequence
    push_burst(32'h1, 1);
    request(32'h1, 16'd3);
    neg();
    pos();
    rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_rand", rand_num, 32'h0);
    chk("t6_busy", {31'b0, busy}, 32'h0);
    chk("t6_done", {31'b0, done}, 32'h0);
    chk("t6_queue", exp_q.size(), 32'h0);
    neg();
    pos();
    rst_n = 1'b1;
    burst_seed1("t6_rerun");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
